// File: rtl/axis_adc_boxcar_decimator_pkg.sv
// Shared state enumeration for the boxcar decimator.
package axis_adc_boxcar_decimator_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

endpackage

// File: rtl/axis_adc_boxcar_decimator_lane.sv
// boxcar_lane: one channel's accumulator.
//   aclk, areset : clock, synchronous active-high reset
//   clear        : discard the partial sum (frame flush)
//   beat         : accept sample this cycle
//   first        : this beat starts a new frame (restart from the sample)
//   sample       : two's complement input sample
//   sum          : frame sum including the current sample (combinational)
module boxcar_lane #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int ACC_WIDTH    = 32
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    clear,
  input  logic                    beat,
  input  logic                    first,
  input  logic [SAMPLE_WIDTH-1:0] sample,
  output logic [ACC_WIDTH-1:0]    sum
);

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] ext;

  always_comb begin
    ext = {{(ACC_WIDTH-SAMPLE_WIDTH){sample[SAMPLE_WIDTH-1]}}, sample};
    sum = first ? ext : acc + ext;
  end

  always_ff @(posedge aclk) begin
    if (areset || clear) begin
      acc <= '0;
    end else if (beat) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/axis_adc_boxcar_decimator.sv
// Two-channel boxcar (sum-and-dump) decimator for an unstallable ADC stream.
//   aclk, areset          : clock, synchronous active-high reset
//   cfg_enable            : run when high, flush the partial frame when low
//   cfg_ratio             : decimation ratio N (0 and 1 both mean pass-through)
//   s_axis_tvalid/tdata   : ADC samples, A in low lane, B in high lane
//   m_axis_tvalid/tready/tdata : frame sums, A in low lane, B in high lane
//   sts_overrun           : sticky, a result was dropped on a full output
//   sts_frames            : count of results accepted downstream
module axis_adc_boxcar_decimator
  import axis_adc_boxcar_decimator_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int ACC_WIDTH    = 32,
  parameter int RATIO_WIDTH  = 16
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      cfg_enable,
  input  logic [RATIO_WIDTH-1:0]    cfg_ratio,
  input  logic                      s_axis_tvalid,
  input  logic [2*SAMPLE_WIDTH-1:0] s_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [2*ACC_WIDTH-1:0]    m_axis_tdata,
  output logic                      sts_overrun,
  output logic [31:0]               sts_frames
);

  state_t                 state;
  logic [RATIO_WIDTH-1:0] cnt;
  logic [RATIO_WIDTH-1:0] n_lat;
  logic [RATIO_WIDTH-1:0] neff;
  logic [RATIO_WIDTH-1:0] n_cur;
  logic                   first;
  logic                   flush;
  logic                   beat;
  logic                   last;
  logic                   accept;
  logic [ACC_WIDTH-1:0]   sum_a;
  logic [ACC_WIDTH-1:0]   sum_b;

  // The ratio in force on the first beat of a frame is the live input; later
  // beats use the value latched then, so mid-frame changes wait a frame.
  always_comb begin
    neff   = (cfg_ratio == '0) ? RATIO_WIDTH'(1) : cfg_ratio;
    first  = (cnt == '0);
    n_cur  = first ? neff : n_lat;
    flush  = (state == ACCUM) && !cfg_enable;
    beat   = (state == ACCUM) && cfg_enable && s_axis_tvalid;
    last   = beat && (cnt == n_cur - RATIO_WIDTH'(1));
    accept = m_axis_tvalid && m_axis_tready;
  end

  boxcar_lane #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH),
    .ACC_WIDTH   (ACC_WIDTH)
  ) u_lane_a (
    .aclk  (aclk),
    .areset(areset),
    .clear (flush),
    .beat  (beat),
    .first (first),
    .sample(s_axis_tdata[SAMPLE_WIDTH-1:0]),
    .sum   (sum_a)
  );

  boxcar_lane #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH),
    .ACC_WIDTH   (ACC_WIDTH)
  ) u_lane_b (
    .aclk  (aclk),
    .areset(areset),
    .clear (flush),
    .beat  (beat),
    .first (first),
    .sample(s_axis_tdata[2*SAMPLE_WIDTH-1:SAMPLE_WIDTH]),
    .sum   (sum_b)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      state         <= IDLE;
      cnt           <= '0;
      n_lat         <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      sts_overrun   <= 1'b0;
      sts_frames    <= '0;
    end else begin
      case (state)
        IDLE:  if (cfg_enable) state <= ACCUM;
        ACCUM: begin
          if (!cfg_enable) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (beat) begin
            if (first) n_lat <= neff;
            cnt <= last ? '0 : cnt + RATIO_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase

      if (accept) sts_frames <= sts_frames + 32'd1;

      // A new result may replace the held one only if it leaves this cycle.
      if (last) begin
        if (!m_axis_tvalid || m_axis_tready) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= {sum_b, sum_a};
        end else begin
          sts_overrun <= 1'b1;
        end
      end else if (accept) begin
        m_axis_tvalid <= 1'b0;
      end

      // No beats are taken while disabled, so this cannot race a new overrun.
      if (!cfg_enable) sts_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_adc_boxcar_decimator.sv
module tb_axis_adc_boxcar_decimator;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        cfg_enable = 1'b0;
  logic [15:0] cfg_ratio = '0;
  logic        s_axis_tvalid = 1'b0;
  logic [31:0] s_axis_tdata = '0;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic [63:0] m_axis_tdata;
  logic        sts_overrun;
  logic [31:0] sts_frames;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: a frame is the list of samples collected since the last
  // dump; its result is the plain integer sum once the list reaches N.
  int          frm_a[$];
  int          frm_b[$];
  int          frm_n = 1;
  bit          r_run = 0;
  bit          r_valid = 0;
  logic [31:0] r_a = '0;
  logic [31:0] r_b = '0;
  bit          r_ovr = 0;
  logic [31:0] r_frames = '0;

  axis_adc_boxcar_decimator #(
    .SAMPLE_WIDTH(16),
    .ACC_WIDTH   (32),
    .RATIO_WIDTH (16)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .cfg_enable   (cfg_enable),
    .cfg_ratio    (cfg_ratio),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tdata (s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .sts_overrun  (sts_overrun),
    .sts_frames   (sts_frames)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lane_sum(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  task automatic model_step();
    bit accept;
    bit new_res = 0;
    int sa, sb;
    if (areset) begin
      frm_a.delete(); frm_b.delete();
      r_run = 0; r_valid = 0; r_a = '0; r_b = '0; r_ovr = 0; r_frames = '0;
      return;
    end
    accept = r_valid && m_axis_tready;
    if (accept) r_frames++;
    if (!r_run) begin
      if (cfg_enable) r_run = 1;
    end else if (!cfg_enable) begin
      r_run = 0;
      frm_a.delete(); frm_b.delete();
    end else if (s_axis_tvalid) begin
      if (frm_a.size() == 0) frm_n = (cfg_ratio == 0) ? 1 : int'(cfg_ratio);
      frm_a.push_back(int'($signed(s_axis_tdata[15:0])));
      frm_b.push_back(int'($signed(s_axis_tdata[31:16])));
      if (frm_a.size() == frm_n) begin
        new_res = 1;
        sa = lane_sum(frm_a);
        sb = lane_sum(frm_b);
        frm_a.delete(); frm_b.delete();
      end
    end
    if (new_res) begin
      if (!r_valid || accept) begin
        r_valid = 1; r_a = sa; r_b = sb;
      end else begin
        r_ovr = 1;
      end
    end else if (accept) begin
      r_valid = 0;
    end
    if (!cfg_enable) r_ovr = 0;
  endtask

  // One clock: model consumes the same pre-edge inputs the DUT sees, then
  // outputs are compared shortly after the edge.
  task automatic cycle();
    @(posedge aclk);
    model_step();
    #1;
    check("tvalid", 64'(m_axis_tvalid), 64'(r_valid));
    if (r_valid) check("tdata", m_axis_tdata, {r_b, r_a});
    check("overrun", 64'(sts_overrun), 64'(r_ovr));
    check("frames", 64'(sts_frames), 64'(r_frames));
  endtask

  task automatic beat(input logic [15:0] a, input logic [15:0] b);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = {b, a};
    cycle();
    s_axis_tvalid = 1'b0;
  endtask

  initial begin
    cycle();
    cycle();
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tdata", m_axis_tdata, 64'd0);
    check("rst_frames", 64'(sts_frames), 64'd0);
    areset = 1'b0;

    // N=4, A=1..8, B=-1
    cfg_enable = 1'b1; cfg_ratio = 16'd4; m_axis_tready = 1'b1;
    cycle();
    for (int i = 1; i <= 8; i++) begin
      beat(16'(i), 16'hFFFF);
      if (i == 4) check("n4_first", m_axis_tdata, 64'hFFFFFFFC_0000000A);
      if (i == 8) check("n4_second", m_axis_tdata, 64'hFFFFFFFC_0000001A);
    end
    cycle();
    check("n4_frames", 64'(sts_frames), 64'd2);

    // Pass-through with N=0 and N=1
    cfg_ratio = 16'd0;
    beat(16'h8000, 16'h7FFF);
    check("n0_sext", m_axis_tdata, 64'h00007FFF_FFFF8000);
    cfg_ratio = 16'd1;
    beat(16'h0003, 16'hFFFE);
    check("n1_pass", m_axis_tdata, 64'hFFFFFFFE_00000003);
    cycle();

    // N=2, downstream stalled: first result held, later ones dropped
    cfg_ratio = 16'd2; m_axis_tready = 1'b0;
    for (int i = 0; i < 6; i++) beat(16'd1, 16'd1);
    check("ovr_set", 64'(sts_overrun), 64'd1);
    check("ovr_held", m_axis_tdata, 64'h00000002_00000002);
    m_axis_tready = 1'b1;
    cycle();

    // N=3, flush a partial frame then a full frame of 5s
    cfg_enable = 1'b0; cycle();
    check("ovr_clear", 64'(sts_overrun), 64'd0);
    cfg_enable = 1'b1; cfg_ratio = 16'd3; cycle();
    beat(16'd7, 16'd7); beat(16'd7, 16'd7);
    cfg_enable = 1'b0; cycle();
    check("flush_noout", 64'(m_axis_tvalid), 64'd0);
    cfg_enable = 1'b1; cycle();
    for (int i = 0; i < 3; i++) beat(16'd5, 16'd5);
    check("flush_15", m_axis_tdata, 64'h0000000F_0000000F);
    check("flush_novr", 64'(sts_overrun), 64'd0);

    // N=4 with ratio changed to 2 mid-frame
    cfg_ratio = 16'd4;
    beat(16'd1, 16'd0); beat(16'd1, 16'd0);
    cfg_ratio = 16'd2;
    beat(16'd1, 16'd0); beat(16'd1, 16'd0);
    check("ratio_old", m_axis_tdata, 64'h00000000_00000004);
    beat(16'd3, 16'd0); beat(16'd3, 16'd0);
    check("ratio_new", m_axis_tdata, 64'h00000000_00000006);

    // Reset mid-frame with a pending result
    m_axis_tready = 1'b0;
    beat(16'd9, 16'd9); beat(16'd9, 16'd9); beat(16'd9, 16'd9);
    areset = 1'b1; cycle();
    check("rst_mid_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_mid_frames", 64'(sts_frames), 64'd0);
    check("rst_mid_ovr", 64'(sts_overrun), 64'd0);
    areset = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      areset        = ($urandom_range(0, 499) == 0);
      cfg_enable    = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 19) == 0) cfg_ratio = 16'($urandom_range(0, 6));
      s_axis_tvalid = ($urandom_range(0, 3) != 0);
      s_axis_tdata  = $urandom;
      m_axis_tready = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axis_adc_boxcar_decimator.md
AXIS_ADC_BOXCAR_DECIMATOR -- requirements
Module: axis_adc_boxcar_decimator

Interface
REQ-001 The block SHALL have parameter SAMPLE_WIDTH, default 16: width of each signed input sample lane.
REQ-002 The block SHALL have parameter ACC_WIDTH, default 32: width of each accumulator and each output sum lane.
REQ-003 The block SHALL have parameter RATIO_WIDTH, default 16: width of cfg_ratio.
REQ-004 The block SHALL have port aclk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 The block SHALL have port areset, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port cfg_enable, input, 1 bit: run when high, flush the partial frame when low.
REQ-007 The block SHALL have port cfg_ratio, input, RATIO_WIDTH bits: decimation ratio N, unsigned.
REQ-008 The block SHALL have port s_axis_tvalid, input, 1 bit: ADC sample valid. There is no tready; upstream cannot stall.
REQ-009 The block SHALL have port s_axis_tdata, input, 2*SAMPLE_WIDTH bits: channel A in [15:0], channel B in [31:16], both two's complement.
REQ-010 The block SHALL have port m_axis_tvalid, input... correction: output, 1 bit: result valid.
REQ-011 The block SHALL have port m_axis_tready, input, 1 bit: downstream accept.
REQ-012 The block SHALL have port m_axis_tdata, output, 2*ACC_WIDTH bits: sum A in [31:0], sum B in [63:32].
REQ-013 The block SHALL have port sts_overrun, output, 1 bit: sticky flag for a dropped result.
REQ-014 The block SHALL have port sts_frames, output, 32 bits: count of results accepted downstream.

Function
REQ-015 The block SHALL sign-extend each input lane to ACC_WIDTH before adding it.
REQ-016 The block SHALL use an effective ratio Neff = max(cfg_ratio, 1), so 0 and 1 both mean pass-through.
REQ-017 The block SHALL latch Neff on the first beat of each frame (cnt==0); a cfg_ratio change mid-frame SHALL take effect at the next frame.
REQ-018 The block SHALL have two states, IDLE and ACCUM; IDLE->ACCUM when cfg_enable=1; ACCUM->IDLE when cfg_enable=0, clearing cnt and discarding the partial sums.
REQ-019 In ACCUM, on each s_axis_tvalid beat, the block SHALL set acc<=sample when cnt==0, otherwise acc<=acc+sample, and SHALL increment cnt.
REQ-020 On the beat with cnt==Neff-1, the block SHALL load acc+sample into the output register, set m_axis_tvalid=1 on the next cycle (latency 1 cycle), and set cnt<=0.
REQ-021 Beats arriving while in IDLE SHALL be ignored.
REQ-022 The output register SHALL hold m_axis_tdata stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-023 When m_axis_tvalid and m_axis_tready are both 1, the block SHALL clear m_axis_tvalid next cycle unless a new result loads in the same cycle, and SHALL increment sts_frames (32-bit wrap).
REQ-024 Same-cycle accept and new result SHALL load the new result, keep tvalid=1, and SHALL NOT flag overrun.
REQ-025 A new result arriving while the register is full and not accepted SHALL be dropped, the held data SHALL be kept, and sts_overrun SHALL be set.
REQ-026 sts_overrun SHALL be cleared only by areset or by cfg_enable going low.
REQ-027 A pending output result SHALL survive cfg_enable going low and remain until accepted.
REQ-028 ACC_WIDTH >= SAMPLE_WIDTH+RATIO_WIDTH guarantees no accumulator overflow; no saturation logic SHALL be implemented.

Reset
REQ-029 On areset=1, the block SHALL set state=IDLE, cnt=0, acc=0, m_axis_tvalid=0, m_axis_tdata=0, sts_overrun=0 and sts_frames=0.
REQ-030 areset SHALL override all other inputs in the same cycle, including mid-frame and with a pending result (the result is lost).

Structure
REQ-031 Only the state enumeration (IDLE, ACCUM) SHALL be placed in a shared package; the module SHALL have no other shared constants.
REQ-032 A single sub-module, boxcar_lane (one accumulator for one channel), SHALL be instantiated twice; the counter and FSM SHALL stay in the top level.

Verification
REQ-033 With N=4, tready=1, A lane=1..8 and B lane=-1 constant, the outputs SHALL be {A=10,B=-4} then {A=26,B=-4}, each 1 cycle after the 4th beat; sts_frames=2.
REQ-034 With N=0 and N=1, each input beat SHALL produce one output equal to the sign-extended input, e.g. 0x8000 -> 0xFFFF8000.
REQ-035 With N=2, tready=0 for 6 beats of value 1, the first result (2) SHALL be held, the 2nd and 3rd results dropped, and sts_overrun=1; after tready=1, the accepted data SHALL be 2.
REQ-036 With N=3, deasserting cfg_enable after 2 beats, then re-enabling with 3 beats of 5, the output SHALL be 15 only (no partial-frame output), and sts_overrun SHALL be 0.
REQ-037 With N=4, changing cfg_ratio to 2 at beat 2, the first result SHALL cover 4 beats and the following results 2 beats.
REQ-038 Asserting areset mid-frame with a pending result SHALL give m_axis_tvalid=0 next cycle, and counters and flags SHALL read 0.
